vldrdy_pack2: RTL

//  Downstream consumer of the 8-bit valid/ready master stream. Collects two

---
 rtl/vldrdy_pack2.sv | 117 +++++++++++
 1 files changed

// File: rtl/vldrdy_pack2.sv
// Packs two consecutive DWIDTH-bit valid/ready input beats into one 2*DWIDTH
// word on a registered valid/ready output, at full throughput.
module vldrdy_pack2 #(
  parameter int DWIDTH    = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_en,
  input  logic                  src_val,
  output logic                  src_rdy,
  input  logic [DWIDTH-1:0]     src_data,
  output logic                  dst_val,
  input  logic                  dst_rdy,
  output logic [2*DWIDTH-1:0]   dst_data,
  output logic [CNT_W-1:0]      word_cnt,
  output logic [1:0]            o_dbg_state
);

  // Handshake rule on both sides: a beat/word transfers on a rising edge
  // where valid and ready are both high; valid never waits on ready.

  // State encoding is {hi_vld, dst_val}, so the flags fall straight out of it.
  typedef enum logic [1:0] {
    S_EMPTY    = 2'b00,
    S_OUT      = 2'b01,
    S_HALF     = 2'b10,
    S_OUT_HALF = 2'b11
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DWIDTH-1:0]     r_hi;
  logic [2*DWIDTH-1:0]   r_data;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_src_hs;
  logic                  w_dst_hs;
  logic                  w_load_hi;
  logic                  w_load_word;
  logic [2*DWIDTH-1:0]   w_packed;

  // A second beat needs the output register empty or draining this cycle.
  assign src_rdy  = rst_n & cfg_en & (~r_state[1] | ~r_state[0] | dst_rdy);
  assign w_src_hs = src_val & src_rdy;
  assign w_dst_hs = r_state[0] & dst_rdy;
  assign w_packed = MSB_FIRST ? {r_hi, src_data} : {src_data, r_hi};

  always_comb begin
    w_next      = r_state;
    w_load_hi   = 1'b0;
    w_load_word = 1'b0;
    if (!cfg_en) begin
      w_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_src_hs) begin
            w_next    = S_HALF;
            w_load_hi = 1'b1;
          end
        end
        S_HALF: begin
          if (w_src_hs) begin
            w_next      = S_OUT;
            w_load_word = 1'b1;
          end
        end
        S_OUT: begin
          if (w_src_hs) begin
            w_load_hi = 1'b1;
            w_next    = w_dst_hs ? S_HALF : S_OUT_HALF;
          end else if (w_dst_hs) begin
            w_next = S_EMPTY;
          end
        end
        S_OUT_HALF: begin
          // src_hs here implies dst_hs, so the new word replaces the old one.
          if (w_src_hs) begin
            w_next      = S_OUT;
            w_load_word = 1'b1;
          end else if (w_dst_hs) begin
            w_next = S_HALF;
          end
        end
        default: w_next = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_hi    <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_load_hi) begin
        r_hi <= src_data;
      end
      if (w_load_word) begin
        r_data <= w_packed;
      end
      // Counts even when cfg_en drops in the same cycle as the handshake.
      if (w_dst_hs) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign dst_val     = r_state[0];
  assign dst_data    = r_data;
  assign word_cnt    = r_cnt;
  assign o_dbg_state = r_state;

endmodule
